dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Round-robin arbiter and sequencer sharing the single-port DataMemory between NUM_REQ requesters (e.g. load/store unit, debug/DMA port).
- Accepts one word request at a time via valid/ready, runs one memory access cycle, then returns a response (read data or write ack) on a valid/ready response channel.
- Sits between the requesters and DataMemory; it is the only driver of the DataMemory address, write_data and write_enable inputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- MEM_BYTES, 1024, DataMemory size in bytes; addresses at or above it are out of range

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed byte addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response ready
- rsp_rdata  out  DATA_W  read data, qualified by rsp_valid
- rsp_err  out  1  misaligned or out-of-range access, qualified by rsp_valid
- mem_address  out  ADDR_W  to DataMemory address
- mem_write_data  out  DATA_W  to DataMemory write_data
- mem_write_enable  out  1  to DataMemory write_enable
- mem_read_data  in  DATA_W  from DataMemory read_data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Memory model: read_data is combinational on address; write commits on the rising clk edge while write_enable = 1.
- Reset (async, rst_n = 0): state IDLE. All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_*, busy. Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has top priority first.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready is combinational. It is one-hot on the first valid requester scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - On that edge: latch index, we, addr, wdata; last_grant <= index; go to ACCESS.
  - No request valid: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_address = latched addr.
  - mem_write_data = latched wdata.
  - mem_write_enable = latched we & ok, where ok = (addr[1:0] == 0) && (addr < MEM_BYTES).
  - On the edge: rsp_rdata <= (!we && ok) ? mem_read_data : 0; rsp_err <= !ok; go to RESP.
  - Outside ACCESS, mem_write_enable = 0 and mem_address / mem_write_data = 0.
- RESP:
  - rsp_valid[index] = 1; rsp_rdata and rsp_err held stable.
  - Leave to IDLE on the edge where rsp_ready[index] = 1; rsp_valid drops the next cycle.
  - rsp_ready already high on entry means RESP lasts exactly 1 cycle.
- Latency: request accepted at edge N, memory access during cycle N+1, rsp_valid high in cycle N+2. Maximum throughput is one transaction per 3 cycles.
- req_ready is 0 in ACCESS and RESP. Requests asserted then are held by the requester and not lost. The granted requester may re-request during RESP; it gets lowest priority in the next IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Errored writes never assert mem_write_enable.
- Reset mid-operation: rst_n low in ACCESS drops mem_write_enable immediately, so no write commits at a later edge. A pending response is discarded and rsp_valid is cleared.

Decomposition:
- Package dmem_arb_pkg holds: state enum (IDLE, ACCESS, RESP); localparam IDX_W = $clog2(NUM_REQ); alignment mask constant.
- One sub-module, rr_pick. It is combinational: inputs valid vector and last_grant; outputs one-hot grant and index. Instantiated by dmem_arbiter.

Test Plan:
- Single write then read, requester 0: write 0x12345678 at 0x00. mem_write_enable high exactly one cycle, rsp_valid[0] at N+2 with rsp_err=0. Read 0x00 returns rsp_rdata=0x12345678.
- Contention: both requesters valid continuously, reads from 0x04 / 0x08 (preloaded 0xA5A5A5A5 / 0x5A5A5A5A). Grants alternate 0,1,0,1. Each rsp_rdata matches its own address; the first grant goes to requester 0 after reset.
- Back-pressure: hold rsp_ready[1]=0 for 5 cycles. rsp_valid[1], rsp_rdata and busy stay stable, req_ready stays 0 and requester 0 waits. Release gives one-cycle handoff to IDLE.
- Errors: write to 0x02, then write to MEM_BYTES (0x400). rsp_err=1 and rsp_rdata=0 each time, mem_write_enable never high. A follow-up read of 0x00 is unchanged.
- Async reset in ACCESS of a write to 0x10 (value 0xDEADBEEF): pull rst_n low mid-cycle before the edge. Outputs go to 0 immediately; a later read of 0x10 returns the old value. Requester 0 has priority after reset.
- Idle behaviour: no req_valid for 10 cycles. busy=0, all mem_* outputs 0, no rsp_valid.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the DataMemory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Low address bits that must be zero for a word access
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Requester index width; a single requester still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Chooses the first valid requester after i_last, wrapping around.
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_any
);

  int w_dist;
  int w_best;

  // Distance from i_last+1 (mod NUM_REQ); the smallest valid distance wins
  always_comb begin
    w_dist  = 0;
    w_best  = NUM_REQ;
    o_index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_valid[i]) begin
        w_dist = i - int'(i_last) - 1;
        if (w_dist < 0) w_dist = w_dist + NUM_REQ;
        if (w_dist < w_best) begin
          w_best  = w_dist;
          o_index = IDX_W'(i);
        end
      end
    end
    o_any = (w_best < NUM_REQ);
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = o_any && (o_index == IDX_W'(i));
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter/sequencer for the single-port DataMemory
// One request at a time: IDLE grant, one ACCESS cycle, then RESP until accepted.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_write_data,
  output logic                      mem_write_enable,
  input  logic [DATA_W-1:0]         mem_read_data,
  output logic                      busy
);

  localparam int                IDX_W     = idx_width(NUM_REQ);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_last;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_index;
  logic                w_any;
  logic                w_ok;
  logic                w_in_access;
  logic [NUM_REQ-1:0]  w_idx_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_index (w_index),
    .o_any   (w_any)
  );

  assign w_ok         = ((r_addr[1:0] & ALIGN_MASK) == 2'b00) && (r_addr < MEM_LIMIT);
  assign w_in_access  = (r_state == ST_ACCESS);
  assign w_idx_onehot = NUM_REQ'(1) << r_idx;

  // Gated by rst_n so nothing is offered while reset is held
  assign req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;

  // Memory strobes are decoded from state, so an async reset kills a write at once
  assign mem_address      = w_in_access ? r_addr  : '0;
  assign mem_write_data   = w_in_access ? r_wdata : '0;
  assign mem_write_enable = w_in_access && r_we && w_ok;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_idx   <= w_index;
            r_last  <= w_index;
            r_we    <= req_we[w_index];
            r_addr  <= req_addr[w_index*ADDR_W +: ADDR_W];
            r_wdata <= req_wdata[w_index*DATA_W +: DATA_W];
            r_busy  <= 1'b1;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_rdata     <= (!r_we && w_ok) ? mem_read_data : '0;
          r_err       <= !w_ok;
          r_rsp_valid <= w_idx_onehot;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[r_idx]) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter with a behavioural DataMemory
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .NUM_REQ   (2),
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_BYTES (1024)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data),
    .busy             (busy)
  );

  logic [31:0] mem [0:255];
  assign mem_read_data = (mem_address < 32'd1024) ? mem[mem_address[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_write_enable && mem_address < 32'd1024) mem[mem_address[9:2]] <= mem_write_data;
  end

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd0;
    logic [1:0]  e_req_ready;
    logic [1:0]  e_rsp_valid;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd0,
                              input logic [1:0] e_rr, input logic [1:0] e_rv, input logic [31:0] e_rd,
                              input logic e_err, input logic e_mwe, input logic [31:0] e_ma,
                              input logic [31:0] e_mwd, input logic e_busy);
    vec_t v;
    v.valid = valid; v.we = we; v.a0 = a0; v.a1 = a1; v.wd0 = wd0;
    v.e_req_ready = e_rr; v.e_rsp_valid = e_rv; v.e_rdata = e_rd; v.e_err = e_err;
    v.e_mwe = e_mwe; v.e_maddr = e_ma; v.e_mwdata = e_mwd; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1]   = 32'hA5A5A5A5;
    mem[2]   = 32'h5A5A5A5A;
    mem[4]   = 32'h11111111;
    mem[255] = 32'hCAFEF00D;

    // Contention after reset: requester 0 first, then strict alternation
    for (int r = 0; r < 2; r++) begin
      vq.push_back(mk(2'b11, 2'b00, 32'h4, 32'h8, 32'h0, 2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
      vq.push_back(mk(2'b11, 2'b00, 32'h4, 32'h8, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 32'h4, 32'h0, 1'b1));
      vq.push_back(mk(2'b11, 2'b00, 32'h4, 32'h8, 32'h0, 2'b00, 2'b01, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
      vq.push_back(mk(2'b11, 2'b00, 32'h4, 32'h8, 32'h0, 2'b10, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
      vq.push_back(mk(2'b11, 2'b00, 32'h4, 32'h8, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1));
      vq.push_back(mk(2'b11, 2'b00, 32'h4, 32'h8, 32'h0, 2'b00, 2'b10, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
    end
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    // Write then read back at 0x00
    vq.push_back(mk(2'b01, 2'b01, 32'h0, 32'h0, 32'h12345678, 2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b1));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
    vq.push_back(mk(2'b01, 2'b00, 32'h0, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
    // Misaligned and out-of-range writes, then unchanged read, then last in-range word
    vq.push_back(mk(2'b01, 2'b01, 32'h2, 32'h0, 32'hFFFFFFFF, 2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 32'h2, 32'hFFFFFFFF, 1'b1));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1));
    vq.push_back(mk(2'b01, 2'b01, 32'h400, 32'h0, 32'hFFFFFFFF, 2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 32'h400, 32'hFFFFFFFF, 1'b1));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1));
    vq.push_back(mk(2'b01, 2'b00, 32'h0, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
    vq.push_back(mk(2'b01, 2'b00, 32'h3FC, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 32'h3FC, 32'h0, 1'b1));
    vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
    // Ten idle cycles
    for (int i = 0; i < 10; i++)
      vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));

    // Reset state, with requests already asserted
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mem_we", mem_write_enable, 1'b0);
    chk("rst_mem_addr", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    req_valid = 2'b00;
    step_drive();
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      if (i != 0) step_drive();
      req_valid = vq[i].valid;
      req_we    = vq[i].we;
      req_addr  = {vq[i].a1, vq[i].a0};
      req_wdata = {32'h0, vq[i].wd0};
      rsp_ready = 2'b11;
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", i), req_ready, vq[i].e_req_ready);
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vq[i].e_rsp_valid);
      chk($sformatf("v%0d_busy", i), busy, vq[i].e_busy);
      chk($sformatf("v%0d_mem_we", i), mem_write_enable, vq[i].e_mwe);
      chk($sformatf("v%0d_mem_addr", i), mem_address, vq[i].e_maddr);
      chk($sformatf("v%0d_mem_wdata", i), mem_write_data, vq[i].e_mwdata);
      if (vq[i].e_rsp_valid != 2'b00) begin
        chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vq[i].e_rdata);
        chk($sformatf("v%0d_rsp_err", i), rsp_err, vq[i].e_err);
      end
    end

    // Back-pressure on requester 1 while requester 0 waits
    step_drive();
    req_valid = 2'b10; req_we = 2'b00; req_addr = {32'h8, 32'h0}; rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_grant1", req_ready, 2'b10);
    step_drive();
    req_valid = 2'b01;
    @(negedge clk);
    chk("bp_access_ready", req_ready, 2'b00);
    step_drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_rsp_valid", c), rsp_valid, 2'b10);
      chk($sformatf("bp%0d_rdata", c), rsp_rdata, 32'h5A5A5A5A);
      chk($sformatf("bp%0d_busy", c), busy, 1'b1);
      chk($sformatf("bp%0d_req_ready", c), req_ready, 2'b00);
      step_drive();
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 2'b10);
    step_drive();
    @(negedge clk);
    chk("bp_after_valid", rsp_valid, 2'b00);
    chk("bp_after_busy", busy, 1'b0);
    chk("bp_after_grant0", req_ready, 2'b01);
    step_drive();
    req_valid = 2'b00;
    step_drive();
    @(negedge clk);
    chk("bp_r0_valid", rsp_valid, 2'b01);
    chk("bp_r0_rdata", rsp_rdata, 32'h12345678);
    step_drive();

    // Async reset while a write to 0x10 sits in ACCESS
    req_valid = 2'b01; req_we = 2'b01; req_addr = {32'h0, 32'h10}; req_wdata = {32'h0, 32'hDEADBEEF};
    @(negedge clk);
    chk("ar_grant", req_ready, 2'b01);
    step_drive();
    req_valid = 2'b00; req_we = 2'b00;
    @(negedge clk);
    chk("ar_access_we", mem_write_enable, 1'b1);
    chk("ar_access_addr", mem_address, 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_we_drop", mem_write_enable, 1'b0);
    chk("ar_addr_drop", mem_address, 32'h0);
    chk("ar_wdata_drop", mem_write_data, 32'h0);
    chk("ar_busy_drop", busy, 1'b0);
    chk("ar_rsp_valid", rsp_valid, 2'b00);
    step_drive();
    chk("ar_mem_unchanged", mem[4], 32'h11111111);
    rst_n = 1'b1;
    req_valid = 2'b11; req_addr = {32'h8, 32'h10};
    @(negedge clk);
    chk("ar_prio0", req_ready, 2'b01);
    step_drive();
    req_valid = 2'b00;
    step_drive();
    @(negedge clk);
    chk("ar_read_valid", rsp_valid, 2'b01);
    chk("ar_read_old", rsp_rdata, 32'h11111111);
    chk("ar_read_err", rsp_err, 1'b0);
    step_drive();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
